approx_mult_ctrl: RTL and testbench

Sequencing controller for the approximate 16x16 multiplier datapath. It accepts a start request and loads both operand shift registers. It then left-shifts each register independently until its leading one reaches bit 15, and stores the top 8 bits of each register. Finally it enables the 8x8 multiplier and reports the per-operand shift counts, so the output stage can shift the product back by `2*W - 16 - cnt_a - cnt_b` bits.

---
 rtl/approx_mult_ctrl_pkg.sv | 16 +
 rtl/approx_mult_ctrl_norm_counter.sv | 46 ++++
 rtl/approx_mult_ctrl.sv | 155 +++++++++++++++
 tb/tb_approx_mult_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_ctrl_pkg.sv
// Shared types and constants for the approximate-multiplier sequencing controller.
package approx_mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    NORM  = 3'd2,
    STORE = 3'd3,
    MULT  = 3'd4,
    DONE  = 3'd5
  } ctrl_state_t;

  localparam int W_DEF  = 16;
  localparam int PROD_W = 8;

endpackage

// File: rtl/approx_mult_ctrl_norm_counter.sv
// Per-operand normalisation tracker: counts left shifts until the leading one
// reaches the MSB or the shift cap of W-1 is hit.
module norm_counter
  import approx_mult_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_active,
  input  logic             i_msb,
  output logic             o_shift,
  output logic             o_finished,
  output logic             o_zero,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_below_max;

  assign w_below_max = (r_cnt < CNT_MAX);

  // The shift strobe follows msb combinationally so a shift lands in the same NORM cycle.
  assign o_shift    = i_active && !i_msb && w_below_max;
  assign o_finished = i_msb || !w_below_max;
  assign o_zero     = !w_below_max && !i_msb;
  assign o_cnt      = r_cnt;

  // Shift counter: cleared when an operation is accepted, bumped on each shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (o_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/approx_mult_ctrl.sv
// Sequencing controller for the approximate 16x16 multiplier datapath.
// Optional zero-operand fast path enabled by defining APPROX_ZERO_SKIP_EN.
module approx_mult_ctrl
  import approx_mult_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int CNT_W    = $clog2(W),
  parameter int MULT_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             msb_a,
  input  logic             msb_b,
  output logic             ldA,
  output logic             ldB,
  output logic             shiftA,
  output logic             shiftB,
  output logic             storeA,
  output logic             storeB,
  output logic             mult_en,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             busy,
  output logic             done,
  output logic             zero_out
);

`ifdef APPROX_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  localparam logic [3:0] MCNT_INIT = 4'(MULT_CYC - 1);

  ctrl_state_t r_state;
  logic        r_ld;
  logic        r_store;
  logic        r_mult_en;
  logic        r_done;
  logic        r_zero_out;
  logic [3:0]  r_mcnt;

  logic w_go;
  logic w_norm;
  logic w_fin_a;
  logic w_fin_b;
  logic w_zero_a;
  logic w_zero_b;

  assign w_go   = (r_state == IDLE) && start;
  assign w_norm = (r_state == NORM);

  norm_counter #(.W(W), .CNT_W(CNT_W)) u_norm_a (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_go),
    .i_active   (w_norm),
    .i_msb      (msb_a),
    .o_shift    (shiftA),
    .o_finished (w_fin_a),
    .o_zero     (w_zero_a),
    .o_cnt      (cnt_a)
  );

  norm_counter #(.W(W), .CNT_W(CNT_W)) u_norm_b (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_go),
    .i_active   (w_norm),
    .i_msb      (msb_b),
    .o_shift    (shiftB),
    .o_finished (w_fin_b),
    .o_zero     (w_zero_b),
    .o_cnt      (cnt_b)
  );

  // Control FSM; strobes are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ld       <= 1'b0;
      r_store    <= 1'b0;
      r_mult_en  <= 1'b0;
      r_done     <= 1'b0;
      r_zero_out <= 1'b0;
      r_mcnt     <= 4'd0;
    end else begin
      r_ld      <= 1'b0;
      r_store   <= 1'b0;
      r_mult_en <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_ld       <= 1'b1;
            r_zero_out <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD: begin
          r_state <= NORM;
        end
        NORM: begin
          if (w_fin_a && w_fin_b) begin
            if (ZERO_SKIP && (w_zero_a || w_zero_b)) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_zero_out <= 1'b1;
            end else begin
              r_state <= STORE;
              r_store <= 1'b1;
            end
          end else begin
            r_state <= NORM;
          end
        end
        STORE: begin
          r_state   <= MULT;
          r_mult_en <= 1'b1;
          r_mcnt    <= MCNT_INIT;
        end
        MULT: begin
          if (r_mcnt == 4'd0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= MULT;
            r_mult_en <= 1'b1;
            r_mcnt    <= r_mcnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ldA      = r_ld;
  assign ldB      = r_ld;
  assign storeA   = r_store;
  assign storeB   = r_store;
  assign mult_en  = r_mult_en;
  assign done     = r_done;
  assign zero_out = r_zero_out;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Self-checking bench for approx_mult_ctrl: two instances (MULT_CYC=1 and 4)
// driven in lockstep, each with its own operand-register model.
module tb_approx_mult_ctrl;

  localparam int W  = 16;
  localparam int CW = 4;

`ifdef APPROX_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  logic [1:0] ld_a, ld_b, sh_a, sh_b, st_a, st_b, men, bsy, dn, zo;
  logic [1:0][CW-1:0] ca, cb;
  logic [1:0][W-1:0]  ra, rb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_mult_ctrl #(.W(W), .CNT_W(CW), .MULT_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .msb_a(ra[0][W-1]), .msb_b(rb[0][W-1]),
    .ldA(ld_a[0]), .ldB(ld_b[0]), .shiftA(sh_a[0]), .shiftB(sh_b[0]),
    .storeA(st_a[0]), .storeB(st_b[0]), .mult_en(men[0]), .cnt_a(ca[0]), .cnt_b(cb[0]),
    .busy(bsy[0]), .done(dn[0]), .zero_out(zo[0])
  );

  approx_mult_ctrl #(.W(W), .CNT_W(CW), .MULT_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .msb_a(ra[1][W-1]), .msb_b(rb[1][W-1]),
    .ldA(ld_a[1]), .ldB(ld_b[1]), .shiftA(sh_a[1]), .shiftB(sh_b[1]),
    .storeA(st_a[1]), .storeB(st_b[1]), .mult_en(men[1]), .cnt_a(ca[1]), .cnt_b(cb[1]),
    .busy(bsy[1]), .done(dn[1]), .zero_out(zo[1])
  );

  // Operand shift registers of the datapath, one pair per instance.
  initial begin
    ra = '0;
    rb = '0;
  end
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ld_a[d]) ra[d] <= op_a;
      else if (sh_a[d]) ra[d] <= {ra[d][W-2:0], 1'b0};
      if (ld_b[d]) rb[d] <= op_b;
      else if (sh_b[d]) rb[d] <= {rb[d][W-2:0], 1'b0};
    end
  end

  function automatic int mcyc(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Shifts needed to bring the leading one to the top, capped at W-1 for zero.
  function automatic int lead_shifts(input logic [W-1:0] x);
    int s;
    s = 0;
    while (s < W - 1 && x[W-1-s] == 1'b0) s++;
    return s;
  endfunction

  function automatic int latency(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = (lead_shifts(a) > lead_shifts(b)) ? lead_shifts(a) : lead_shifts(b);
    if (SKIP && (a == '0 || b == '0)) return 3 + n;
    return 4 + n + mcyc(d);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_outs_d%0d", tag, d),
          int'({ld_a[d], ld_b[d], sh_a[d], sh_b[d], st_a[d], st_b[d], men[d],
                bsy[d], dn[d], zo[d], ca[d], cb[d]}), 0);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n_lda[2], n_ldb[2], n_sa[2], n_sb[2], n_sta[2], n_stb[2], n_mu[2], t_done[2], t_st[2];
    int sa, sb, n, lat;
    bit zero, skp;
    sa = lead_shifts(a);
    sb = lead_shifts(b);
    n = (sa > sb) ? sa : sb;
    zero = (a == '0) || (b == '0);
    skp = SKIP && zero;
    op_a = a;
    op_b = b;
    for (int d = 0; d < 2; d++) begin
      n_lda[d] = 0; n_ldb[d] = 0; n_sa[d] = 0; n_sb[d] = 0;
      n_sta[d] = 0; n_stb[d] = 0; n_mu[d] = 0; t_done[d] = -1; t_st[d] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (t_done[d] < 0) begin
          n_lda[d] += int'(ld_a[d]);
          n_ldb[d] += int'(ld_b[d]);
          n_sa[d]  += int'(sh_a[d]);
          n_sb[d]  += int'(sh_b[d]);
          n_sta[d] += int'(st_a[d]);
          n_stb[d] += int'(st_b[d]);
          n_mu[d]  += int'(men[d]);
          if (st_a[d] && t_st[d] < 0) t_st[d] = k;
          if (dn[d]) begin
            t_done[d] = k;
            chk($sformatf("%s_cnt_a_d%0d", tag, d), int'(ca[d]), sa);
            chk($sformatf("%s_cnt_b_d%0d", tag, d), int'(cb[d]), sb);
            chk($sformatf("%s_zero_out_d%0d", tag, d), int'(zo[d]), int'(skp));
            chk($sformatf("%s_busy_at_done_d%0d", tag, d), int'(bsy[d]), 1);
          end
        end
      end
      if (t_done[0] >= 0 && t_done[1] >= 0) break;
    end
    for (int d = 0; d < 2; d++) begin
      lat = latency(d, a, b);
      chk($sformatf("%s_done_cycle_d%0d", tag, d), t_done[d], lat);
      chk($sformatf("%s_ldA_d%0d", tag, d), n_lda[d], 1);
      chk($sformatf("%s_ldB_d%0d", tag, d), n_ldb[d], 1);
      chk($sformatf("%s_shiftA_d%0d", tag, d), n_sa[d], sa);
      chk($sformatf("%s_shiftB_d%0d", tag, d), n_sb[d], sb);
      chk($sformatf("%s_storeA_d%0d", tag, d), n_sta[d], skp ? 0 : 1);
      chk($sformatf("%s_storeB_d%0d", tag, d), n_stb[d], skp ? 0 : 1);
      chk($sformatf("%s_store_cycle_d%0d", tag, d), t_st[d], skp ? -1 : 3 + n);
      chk($sformatf("%s_mult_en_d%0d", tag, d), n_mu[d], skp ? 0 : mcyc(d));
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("%s_idle_after_d%0d", tag, d), int'(bsy[d]), 0);
  endtask

  task automatic hold_start(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat[2], nld[2], ld1[2], ld2[2], nd[2], d1[2], d2[2];
    int kmax;
    bit idle;
    op_a = a;
    op_b = b;
    kmax = 0;
    for (int d = 0; d < 2; d++) begin
      lat[d] = latency(d, a, b);
      if (2 * lat[d] + 1 > kmax) kmax = 2 * lat[d] + 1;
      nld[d] = 0; ld1[d] = -1; ld2[d] = -1; nd[d] = 0; d1[d] = -1; d2[d] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (k <= 2 * lat[d] + 1) begin
          if (ld_a[d]) begin
            nld[d]++;
            if (ld1[d] < 0) ld1[d] = k; else if (ld2[d] < 0) ld2[d] = k;
          end
          if (dn[d]) begin
            nd[d]++;
            if (d1[d] < 0) d1[d] = k; else if (d2[d] < 0) d2[d] = k;
          end
        end
      end
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("hold_nld_d%0d", d), nld[d], 2);
      chk($sformatf("hold_ld1_d%0d", d), ld1[d], 1);
      chk($sformatf("hold_ld2_d%0d", d), ld2[d], lat[d] + 2);
      chk($sformatf("hold_ndone_d%0d", d), nd[d], 2);
      chk($sformatf("hold_done1_d%0d", d), d1[d], lat[d]);
      chk($sformatf("hold_done2_d%0d", d), d2[d], 2 * lat[d] + 1);
    end
    idle = 1'b0;
    for (int k = 0; k < 80 && !idle; k++) begin
      @(negedge clk);
      idle = (bsy == 2'b00);
    end
    chk("hold_drain_idle", int'(idle), 1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    run_op(16'h0300, 16'h8001, "a0300_b8001");
    run_op(16'h8000, 16'hFFFF, "min_latency");
    run_op(16'h0000, 16'h0001, "zero_a");
    run_op(16'h4000, 16'h4000, "a4000_b4000");
    run_op(16'h0001, 16'h0000, "zero_b");

    // Reset in the third NORM cycle of A=0x0100.
    op_a = 16'h0100;
    op_b = 16'h8000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_shiftA", int'(sh_a), 3);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    chk_all_zero("mid_rst_hold");
    rst = 1'b0;
    run_op(16'h0100, 16'h8000, "post_rst");

    hold_start(16'h8000, 16'hFFFF);

    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      b = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if (i % 6 == 5) a = '0;
      run_op(a, b, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
